// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - APB widths, request/response bundles and subordinate FSM states.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic {APB_IDLE, APB_ACCESS} apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
  } apb_resp_t;

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - word array with byte-enable synchronous write, asynchronous read, sync clear.
module sram_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [DATA_W/8-1:0]      i_strb,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_strb[b]) begin
          r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/apb_sram_subordinate.sv
// rtl/apb_sram_subordinate.sv - APB subordinate over an internal SRAM with wait states and PSLVERR.
module apb_sram_subordinate
  import apb_pkg::*;
#(
  parameter int                    DEPTH       = 1024,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  apb_req_t  i_apb_s_req,
  output apb_resp_t o_apb_s_resp,
  input  logic      i_apb_s_psel,
  input  logic      i_apb_s_penable,
  output logic      o_apb_s_pready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  apb_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  apb_req_t              r_req, w_req_nxt;
  logic                  w_setup, w_access, w_err, w_pready, w_we;
  logic [APB_ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]      w_idx;
  logic [APB_DATA_W-1:0] w_rdata;

  assign w_setup  = i_apb_s_psel & ~i_apb_s_penable;
  assign w_access = i_apb_s_psel & i_apb_s_penable;

  // Decode always works on the latched request so mid-transfer bus changes are ignored.
  assign w_off = r_req.addr - BASE_ADDR;
  assign w_err = (r_req.addr < BASE_ADDR) ||
                 ((w_off >> 2) >= APB_ADDR_W'(DEPTH)) ||
                 (r_req.addr[1:0] != 2'b00);
  assign w_idx = w_off[IDX_W+1:2];

  assign w_pready = rst_n && (r_state == APB_ACCESS) && w_access && (r_cnt == '0);
  assign w_we     = w_pready && r_req.write && !w_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    case (r_state)
      APB_IDLE: begin
        if (w_setup) begin
          w_state_nxt = APB_ACCESS;
          w_cnt_nxt   = CNT_LOAD;
          w_req_nxt   = i_apb_s_req;
        end
      end
      APB_ACCESS: begin
        if (!i_apb_s_psel) begin
          w_state_nxt = APB_IDLE;
        end else if (!i_apb_s_penable) begin
          w_cnt_nxt = CNT_LOAD;
          w_req_nxt = i_apb_s_req;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = APB_IDLE;
        end
      end
      default: w_state_nxt = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= APB_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
    end
  end

  sram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (APB_DATA_W)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (r_req.wdata),
    .i_strb  (r_req.strb),
    .o_rdata (w_rdata)
  );

  assign o_apb_s_pready      = w_pready;
  assign o_apb_s_resp.rdata  = (w_pready && !r_req.write && !w_err) ? w_rdata : '0;
  assign o_apb_s_resp.slverr = w_pready && w_err;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      if (r_state == APB_IDLE && w_access)
        $error("apb_sram_subordinate: PENABLE without SETUP, addr=%h", i_apb_s_req.addr);
      if (r_state == APB_ACCESS && w_access && i_apb_s_req != r_req)
        $error("apb_sram_subordinate: request changed in ACCESS, addr=%h", r_req.addr);
      if (r_state == APB_ACCESS && !i_apb_s_psel)
        $warning("apb_sram_subordinate: transfer aborted before PREADY, addr=%h", r_req.addr);
    end
  end
`endif

endmodule

// File: tb/tb_apb_sram_subordinate.sv
// tb/tb_apb_sram_subordinate.sv - scoreboard bench for three subordinates (0, 1 and 3 wait cycles).
module tb_apb_sram_subordinate;
  import apb_pkg::*;

  localparam int NI = 3;
  localparam int WORDS = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_n, psel, penable;
  wire  [NI-1:0] pready;
  apb_req_t      req  [NI];
  apb_resp_t     resp [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_sram_subordinate #(
      .DEPTH       (WORDS),
      .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 1 : 3),
      .BASE_ADDR   (32'h0)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n[g]),
      .i_apb_s_req     (req[g]),
      .o_apb_s_resp    (resp[g]),
      .i_apb_s_psel    (psel[g]),
      .i_apb_s_penable (penable[g]),
      .o_apb_s_pready  (pready[g])
    );
  end

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        slverr;
  } exp_t;

  int          waits [NI] = '{0, 1, 3};
  logic [31:0] mem [NI][WORDS];
  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  int          idle_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: a transfer either errors (misaligned or outside the 4 KiB window) or hits one word.
  function automatic exp_t predict(input int k, input logic [31:0] a, input bit w,
                                   input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.k = k;
    e.rdata = 32'h0;
    e.slverr = 1'b0;
    if (a % 4 != 0 || a >= 32'(4 * WORDS)) begin
      e.slverr = 1'b1;
    end else if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mem[k][a / 4][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      e.rdata = mem[k][a / 4];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (pready[k]) begin
        if (q.size() == 0) begin
          check("unexpected_pready", 32'(pready[k]), 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("resp_instance", 32'(k), 32'(e.k));
          check("resp_rdata", resp[k].rdata, e.rdata);
          check("resp_slverr", 32'(resp[k].slverr), 32'(e.slverr));
        end
      end else if (resp[k] != '0) begin
        idle_bad++;
      end
    end
  end

  task automatic xfer(input int k, input logic [31:0] a, input bit w,
                      input logic [31:0] d, input logic [3:0] s, input bit keep);
    int cyc;
    @(posedge clk); #1;
    psel[k] = 1'b1;
    penable[k] = 1'b0;
    req[k] = '{addr: a, write: w, wdata: d, strb: s};
    q.push_back(predict(k, a, w, d, s));
    @(posedge clk); #1;
    penable[k] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!pready[k] && cyc < 20);
    check("latency", 32'(cyc), 32'(waits[k] + 1));
    if (!keep) begin
      @(posedge clk); #1;
      psel[k] = 1'b0;
      penable[k] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = '0;
    psel = '0;
    penable = '0;
    for (int k = 0; k < NI; k++) begin
      req[k] = '0;
      for (int i = 0; i < WORDS; i++) mem[k][i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset_pready", 32'(pready[k]), 32'h0);
      check("reset_rdata", resp[k].rdata, 32'h0);
      check("reset_slverr", 32'(resp[k].slverr), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = '1;

    // One wait cycle: full write, partial-strobe merge, error decode.
    xfer(1, 32'h10, 1, 32'hDEADBEEF, 4'hF, 0);
    xfer(1, 32'h10, 0, 32'h0, 4'h0, 0);
    xfer(1, 32'h20, 1, 32'h11223344, 4'hF, 0);
    xfer(1, 32'h20, 1, 32'hAA000000, 4'b1000, 0);
    xfer(1, 32'h20, 0, 32'h0, 4'h0, 0);
    xfer(1, 32'h0, 1, 32'h5A5A0001, 4'hF, 0);
    xfer(1, 32'h1002, 0, 32'h0, 4'h0, 0);
    xfer(1, 32'h1000, 0, 32'h0, 4'h0, 0);
    xfer(1, 32'h1000, 1, 32'hFFFFFFFF, 4'hF, 0);
    xfer(1, 32'h0, 0, 32'h0, 4'h0, 0);

    // Zero wait, back-to-back write then read with psel held.
    xfer(0, 32'h0, 1, 32'hC0FFEE11, 4'hF, 1);
    xfer(0, 32'h0, 0, 32'h0, 4'h0, 0);

    // Reset in the middle of a three-wait write clears the array and suppresses the response.
    xfer(2, 32'h8, 1, 32'h12345678, 4'hF, 0);
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0;
    req[2] = '{addr: 32'h8, write: 1'b1, wdata: 32'hCAFEF00D, strb: 4'hF};
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(negedge clk);
    check("rst_mid_pready_before", 32'(pready[2]), 32'h0);
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    @(negedge clk);
    check("rst_low_pready", 32'(pready[2]), 32'h0);
    check("rst_low_resp", 32'(resp[2]), 32'h0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int i = 0; i < WORDS; i++) mem[2][i] = 32'h0;
    xfer(2, 32'h8, 0, 32'h0, 4'h0, 0);

    // Manager drops psel after one wait cycle: no response, no write.
    xfer(2, 32'h40, 1, 32'h0BADF00D, 4'hF, 0);
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0;
    req[2] = '{addr: 32'h40, write: 1'b1, wdata: 32'hFFFF0000, strb: 4'hF};
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(negedge clk);
    check("abort_pready_wait", 32'(pready[2]), 32'h0);
    @(posedge clk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_pready_after", 32'(pready[2]), 32'h0);
    end
    xfer(2, 32'h40, 0, 32'h0, 4'h0, 0);
    xfer(2, 32'h44, 1, 32'h76543210, 4'b0101, 0);
    xfer(2, 32'h44, 0, 32'h0, 4'h0, 0);

    // Random traffic over a small window so reads frequently hit earlier writes.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 15)) << 2;
        if (r == 0) a = a | 32'($urandom_range(1, 3));
        else if (r == 1) a = 32'h1000 + (32'($urandom_range(0, 1000)) << 2);
        xfer(k, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             (i != 39) && ($urandom_range(0, 1) == 1));
      end
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    check("idle_resp_zero", 32'(idle_bad), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
